mdu_ctrl: RTL and testbench

Multiply/HI-LO controller for the MIPS CPU execute stage. Accepts MULT, MULTU, MTHI and MTLO requests from the pipeline, and sequences a two-stage registered signed 32×32 multiplier core. It applies the unsigned correction for MULTU, owns the architectural HI/LO registers, and drives a busy interlock so the pipeline stalls MFHI/MFLO and new multiplies until the result is committed.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mul_array.sv | 58 +++++
 rtl/mdu_ctrl.sv | 137 +++++++++++++
 tb/tb_mdu_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/HI-LO controller.
//   - request opcode encodings
//   - controller state encoding
//   - default multiplier core latency
//   - helper for the MULTU high-word correction term
package mdu_pkg;

  localparam int unsigned MUL_LAT_DEF = 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    M1   = 2'b01,
    M2   = 2'b10,
    WB   = 2'b11
  } state_e;

  // Turns a signed 32x32 product into the unsigned one: each operand whose MSB is set
  // was read as (x - 2^32), so add the other operand back into the upper word.
  function automatic logic [31:0] umul_hi_corr(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] corr;
    corr = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
    return corr;
  endfunction

endpackage

// File: rtl/mul_array.sv
// mul_array: two-stage registered signed 32x32 -> 64 multiplier (Baugh-Wooley).
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   i_a, i_b   : signed operands, sampled every cycle
//   o_p        : signed product, valid two edges after the operands were presented
module mul_array (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);

  // Baugh-Wooley constant: 2^32 + 2^63 (the -2^63 term folds to +2^63 modulo 2^64).
  localparam logic [63:0] BwConst = 64'h8000_0001_0000_0000;

  logic [31:0] w_row [32];
  logic [31:0] r_row [32];
  logic [63:0] w_sum;
  logic [63:0] r_p;

  // Row i, bit j is a_i & b_j, inverted when exactly one of i, j is the sign position.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_row[i] = (i_b & {32{i_a[i]}}) ^ ((i == 31) ? 32'h7FFF_FFFF : 32'h8000_0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_row[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        r_row[i] <= w_row[i];
      end
    end
  end

  always_comb begin
    w_sum = BwConst;
    for (int i = 0; i < 32; i++) begin
      w_sum = w_sum + ({32'd0, r_row[i]} << i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p <= '0;
    end else begin
      r_p <= w_sum;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply / HI-LO controller for the execute stage.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   start, op       : one-cycle request; op = MULT / MULTU / MTHI / MTLO
//   rs_val, rt_val  : operands (rs_val is also the MTHI/MTLO data)
//   flush           : abort an in-flight multiply, HI/LO untouched
//   busy            : multiply in flight, pipeline must stall HI/LO users
//   done            : one-cycle pulse after a multiply wrote HI/LO
//   hi, lo          : architectural HI/LO registers
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic                r_uns;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic                r_done;
  // Tracks operand sets travelling through the core; the MSB marks a product at the output.
  logic [MUL_LAT-1:0]  r_vld;
  logic [63:0]         w_prod;
  logic [31:0]         w_hi_fix;
  logic                w_idle;
  logic                w_accept_mul;
  logic                w_accept_mt;
  logic                w_commit;

  assign w_idle       = (r_state == IDLE);
  assign w_accept_mul = w_idle & start & ~flush & ~op[1];
  assign w_accept_mt  = w_idle & start & ~flush & op[1];
  assign w_commit     = (r_state == WB) & ~flush & r_vld[MUL_LAT-1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = w_accept_mul ? M1 : IDLE;
      M1:      w_state_nxt = flush ? IDLE : M2;
      M2:      w_state_nxt = flush ? IDLE : WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  // Operand registers hold the core inputs steady for the whole multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_uns <= 1'b0;
    end else if (w_accept_mul) begin
      r_a   <= rs_val;
      r_b   <= rt_val;
      r_uns <= (op == OP_MULTU);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      r_vld    <= r_vld << 1;
      r_vld[0] <= (r_state == M1);
    end
  end

  mul_array u_mul_array (
    .clk   (clk),
    .reset (reset),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_p   (w_prod)
  );

  assign w_hi_fix = w_prod[63:32] + (r_uns ? umul_hi_corr(r_a, r_b) : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_hi_fix;
      r_lo <= w_prod[31:0];
    end else if (w_accept_mt) begin
      if (op == OP_MTHI) begin
        r_hi <= rs_val;
      end else begin
        r_lo <= rs_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Multiplies push their expected {hi,lo} into a
// queue when issued; a monitor pops and compares whenever done pulses.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_vec;
  int          n_err;
  logic [63:0] sb_q [$];
  logic [63:0] mon_exp;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_ctrl #(
    .MUL_LAT (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product, plain 64-bit arithmetic on extended operands.
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    if (o == OP_MULT) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
    end else begin
      xa = {32'd0, a};
      xb = {32'd0, b};
    end
    return xa * xb;
  endfunction

  // Issue a multiply from just after an edge; returns in the done cycle.
  // inj selects a busy cycle in which an MTHI is driven (it must be ignored); -1 = none.
  task automatic do_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj);
    logic [63:0] exp;
    exp = ref_mul(o, a, b);
    sb_q.push_back(exp);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("busy_during_mul", {63'd0, busy}, 64'd1);
      chk("no_early_done", {63'd0, done}, 64'd0);
      if (k == inj) begin
        start = 1'b1; op = OP_MTHI; rs_val = 32'hAAAA_5555;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_clear", {63'd0, busy}, 64'd0);
    chk("hilo_after_mul", {hi, lo}, {hi_m, lo_m});
  endtask

  task automatic do_mt(input logic [1:0] o, input logic [31:0] a);
    if (o == OP_MTHI) hi_m = a;
    else lo_m = a;
    start = 1'b1; op = o; rs_val = a;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hilo_after_mt", {hi, lo}, {hi_m, lo_m});
    chk("mt_no_busy", {63'd0, busy}, 64'd0);
    chk("mt_no_done", {63'd0, done}, 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; flush = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);

    // Asynchronous reset mid-cycle
    do_mt(OP_MTHI, 32'hDEAD_BEEF);
    do_mt(OP_MTLO, 32'hCAFE_F00D);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    do_mt(OP_MTLO, 32'h1234_5678);
    chk("mtlo_value", {32'd0, lo}, 64'h1234_5678);

    // Directed multiplies; consecutive calls issue in the done cycle (back-to-back)
    do_mul(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1);
    chk("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);
    chk("mult_min_sq", {hi, lo}, 64'h4000_0000_0000_0000);
    do_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max_sq", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_mul(OP_MULTU, 32'h8000_0000, 32'd2, -1);
    chk("multu_msb_x2", {hi, lo}, 64'h0000_0001_0000_0000);

    // MTHI while in M2 is ignored
    do_mul(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    do_mul(OP_MULTU, 32'h8765_4321, 32'hF000_000F, 0);

    // Flush in M2, with a simultaneous (ignored) start
    do_mt(OP_MTLO, 32'h11);
    start = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush_busy_m1", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b1; op = OP_MTHI; rs_val = 32'hAAAA_5555;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_idle", {63'd0, busy}, 64'd0);
    chk("flush_no_done", {63'd0, done}, 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {hi_m, lo_m});
    repeat (2) begin
      @(posedge clk); #1;
      chk("flush_no_late_done", {63'd0, done}, 64'd0);
    end

    // Reset while in WB
    start = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wb_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset_hilo", {hi, lo}, 64'd0);
    chk("midop_reset_flags", {62'd0, busy, done}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("midop_reset_no_done", {63'd0, done}, 64'd0);
    do_mul(OP_MULT, 32'd2, 32'd3, -1);
    chk("mult_2x3", {hi, lo}, 64'd6);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) a = {a[0], 31'd0};
      if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
      if (r < 2) do_mul(r[1:0], a, b, -1);
      else do_mt(r[1:0], a);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
